mtm_alu_rx_param: RTL and testbench



---
 rtl/mtm_alu_rx_param.sv | 236 +++++++++++++++++++++++
 tb/tb_mtm_alu_rx_param.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtm_alu_rx_param.sv
// mtm_alu_rx_param: serial packet receiver for the mtm_Alu datapath.
// Each 11-bit frame is: start(0), type (0=DATA, 1=CTL), 8 data bits MSB first, stop(1).
// A packet is 2*OP_BYTES DATA frames (B then A, MS byte first) followed by one CTL frame.
// The CTL frame is {0, OP[2:0], CRC4[3:0]}.
// The result, or an error code, is presented on a valid/ready output that holds its value until accepted.
// Optional feature: define MTM_ALU_RX_TIMEOUT_EN to abort a partial packet after TIMEOUT_CYC idle cycles.
module mtm_alu_rx_param #(
  parameter int OP_BYTES    = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*OP_BYTES-1:0] out_a,
  output logic [8*OP_BYTES-1:0] out_b,
  output logic [2:0]            out_op,
  output logic [2:0]            out_err,
  output logic                  out_overrun,
  output logic                  frame_err
);

  localparam int W     = 8 * OP_BYTES;
  localparam int NDATA = 2 * OP_BYTES;
  localparam int CNT_W = $clog2(NDATA + 2);

  // Reject parameter values outside the supported range at elaboration.
  if (OP_BYTES < 1 || OP_BYTES > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("mtm_alu_rx_param: OP_BYTES must be 1..8 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_TYPE, S_DATA, S_STOP} state_t;

  // One bit of the x^4+x+1 CRC, MSB-first serial form.
  function automatic logic [3:0] crc4_step(input logic [3:0] crc, input logic d);
    logic fb;
    fb = crc[3] ^ d;
    return {crc[2], crc[1], crc[0] ^ fb, fb};
  endfunction

  state_t           state_q, state_d;
  logic             type_q, type_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [6:0]       ctl_q, ctl_d;        // low 7 bits of the frame byte; bit 7 of CTL carries nothing
  logic [2*W-1:0]   data_q, data_d;
  logic [3:0]       crc_q, crc_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic             hold_q, hold_d;      // after a framing error, wait for the line to go high
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_a_q, out_a_d;
  logic [W-1:0]     out_b_q, out_b_d;
  logic [2:0]       out_op_q, out_op_d;
  logic [2:0]       out_err_q, out_err_d;
  logic             out_overrun_q, out_overrun_d;
  logic             frame_err_q, frame_err_d;

  logic             pkt_done;
  logic [W-1:0]     res_a, res_b;
  logic [2:0]       res_op, res_err;
  logic [2:0]       op_rx;
  logic [3:0]       crc_tail;

`ifdef MTM_ALU_RX_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  // The constant '1' marker bit and OP are folded into the running CRC only when the CTL frame lands.
  assign op_rx    = ctl_q[6:4];
  assign crc_tail = crc4_step(crc4_step(crc4_step(crc4_step(crc_q, 1'b1), op_rx[2]), op_rx[1]), op_rx[0]);

  // Next-state logic: frame deserialiser, packet assembly, error evaluation and output handshake.
  always_comb begin
    state_d       = state_q;
    type_d        = type_q;
    bit_cnt_d     = bit_cnt_q;
    ctl_d         = ctl_q;
    data_d        = data_q;
    crc_d         = crc_q;
    dcnt_d        = dcnt_q;
    hold_d        = hold_q;
    out_valid_d   = out_valid_q;
    out_a_d       = out_a_q;
    out_b_d       = out_b_q;
    out_op_d      = out_op_q;
    out_err_d     = out_err_q;
    out_overrun_d = out_overrun_q;
    frame_err_d   = 1'b0;
    pkt_done      = 1'b0;
    res_a         = '0;
    res_b         = '0;
    res_op        = 3'b000;
    res_err       = 3'b000;
`ifdef MTM_ALU_RX_TIMEOUT_EN
    tmo_d         = '0;
`endif

    case (state_q)
      S_IDLE: begin
        if (hold_q) begin
          if (sin) hold_d = 1'b0;
        end else if (!sin) begin
          state_d = S_TYPE;
        end
      end
      S_TYPE: begin
        type_d    = sin;
        bit_cnt_d = 3'd0;
        state_d   = S_DATA;
      end
      S_DATA: begin
        ctl_d     = {ctl_q[5:0], sin};
        // Only DATA frames feed the operand register and the running CRC.
        if (!type_q) begin
          data_d = {data_q[2*W-2:0], sin};
          crc_d  = crc4_step(crc_q, sin);
        end
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = S_STOP;
      end
      S_STOP: begin
        state_d = S_IDLE;
        if (!sin) begin
          // Bad stop bit: drop the whole packet and resynchronise on a high line.
          frame_err_d = 1'b1;
          hold_d      = 1'b1;
          dcnt_d      = '0;
          crc_d       = 4'd0;
          data_d      = '0;
        end else if (!type_q) begin
          if (dcnt_q != CNT_W'(NDATA + 1)) dcnt_d = dcnt_q + 1'b1;
        end else begin
          pkt_done = 1'b1;
          if (dcnt_q != CNT_W'(NDATA)) begin
            res_err = 3'b100;
          end else if (crc_tail != ctl_q[3:0]) begin
            res_err = 3'b010;
          end else if (!(op_rx inside {3'b000, 3'b001, 3'b100, 3'b101})) begin
            res_err = 3'b001;
          end else begin
            res_a  = data_q[W-1:0];
            res_b  = data_q[2*W-1:W];
            res_op = op_rx;
          end
          dcnt_d = '0;
          crc_d  = 4'd0;
          data_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef MTM_ALU_RX_TIMEOUT_EN
    // Idle-gap watchdog: runs only between frames of a partially received packet.
    if (state_q == S_IDLE && dcnt_q != '0 && !hold_q && sin) begin
      if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
        pkt_done = 1'b1;
        res_err  = 3'b100;
        dcnt_d   = '0;
        crc_d    = 4'd0;
        data_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif

    // A finished packet loads only if the output slot is free or is being emptied this cycle.
    if (pkt_done) begin
      if (!out_valid_q || out_ready) begin
        out_valid_d = 1'b1;
        out_a_d     = res_a;
        out_b_d     = res_b;
        out_op_d    = res_op;
        out_err_d   = res_err;
      end else begin
        out_overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      type_q        <= 1'b0;
      bit_cnt_q     <= 3'd0;
      ctl_q         <= 7'd0;
      data_q        <= '0;
      crc_q         <= 4'd0;
      dcnt_q        <= '0;
      hold_q        <= 1'b0;
      out_valid_q   <= 1'b0;
      out_a_q       <= '0;
      out_b_q       <= '0;
      out_op_q      <= 3'b000;
      out_err_q     <= 3'b000;
      out_overrun_q <= 1'b0;
      frame_err_q   <= 1'b0;
`ifdef MTM_ALU_RX_TIMEOUT_EN
      tmo_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      type_q        <= type_d;
      bit_cnt_q     <= bit_cnt_d;
      ctl_q         <= ctl_d;
      data_q        <= data_d;
      crc_q         <= crc_d;
      dcnt_q        <= dcnt_d;
      hold_q        <= hold_d;
      out_valid_q   <= out_valid_d;
      out_a_q       <= out_a_d;
      out_b_q       <= out_b_d;
      out_op_q      <= out_op_d;
      out_err_q     <= out_err_d;
      out_overrun_q <= out_overrun_d;
      frame_err_q   <= frame_err_d;
`ifdef MTM_ALU_RX_TIMEOUT_EN
      tmo_q         <= tmo_d;
`endif
    end
  end

  assign out_valid   = out_valid_q;
  assign out_a       = out_a_q;
  assign out_b       = out_b_q;
  assign out_op      = out_op_q;
  assign out_err     = out_err_q;
  assign out_overrun = out_overrun_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_mtm_alu_rx_param.sv
// Testbench for mtm_alu_rx_param.
// The main instance uses OP_BYTES=4; a second instance uses OP_BYTES=2.
// Results from the main instance are checked against a scoreboard queue.
// The timeout sequence runs only when MTM_ALU_RX_TIMEOUT_EN is defined.
module tb_mtm_alu_rx_param;

  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        sin4, sin2;
  logic        rdy4, rdy2;
  logic        out_valid4, out_valid2;
  logic [31:0] out_a4, out_b4;
  logic [15:0] out_a2, out_b2;
  logic [2:0]  out_op4, out_err4, out_op2, out_err2;
  logic        ovr4, ovr2, ferr4, ferr2;

  always #5 clk = ~clk;

  mtm_alu_rx_param #(.OP_BYTES(4), .TIMEOUT_CYC(TMO)) u_dut4 (
    .clk(clk), .rst(rst), .sin(sin4),
    .out_valid(out_valid4), .out_ready(rdy4),
    .out_a(out_a4), .out_b(out_b4), .out_op(out_op4), .out_err(out_err4),
    .out_overrun(ovr4), .frame_err(ferr4)
  );

  mtm_alu_rx_param #(.OP_BYTES(2), .TIMEOUT_CYC(TMO)) u_dut2 (
    .clk(clk), .rst(rst), .sin(sin2),
    .out_valid(out_valid2), .out_ready(rdy2),
    .out_a(out_a2), .out_b(out_b2), .out_op(out_op2), .out_err(out_err2),
    .out_overrun(ovr2), .frame_err(ferr2)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_ferr = 0;
  int got2   = 0;
  logic [15:0] cap_a2, cap_b2;
  logic [2:0]  cap_op2, cap_err2;

  typedef struct {
    logic [31:0] a, b;
    logic [2:0]  op, err;
  } res_t;
  res_t sbq[$];

  typedef struct {
    logic [31:0] b, a;
    logic [2:0]  op;
    int          ndata;
    bit          use_ctl;
    logic [7:0]  ctl;
    logic [2:0]  e_err;
    logic [31:0] e_a, e_b;
    logic [2:0]  e_op;
  } vec_t;
  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Bench CRC model written as polynomial division: shift left, xor 0011 when the feedback bit is set.
  function automatic logic [3:0] crc_model(input logic [63:0] data, input int nbits, input logic [2:0] op);
    logic [3:0] c;
    logic [3:0] tail;
    logic       fb;
    c = 4'd0;
    tail = {1'b1, op};
    for (int i = nbits - 1; i >= 0; i--) begin
      fb = c[3] ^ data[i];
      c = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    end
    for (int i = 3; i >= 0; i--) begin
      fb = c[3] ^ tail[i];
      c = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    end
    return c;
  endfunction

  task automatic send_bit(input int which, input logic b);
    if (which == 2) sin2 = b;
    else sin4 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int which, input logic typ, input logic [7:0] byt, input logic stop);
    send_bit(which, 1'b0);
    send_bit(which, typ);
    for (int i = 7; i >= 0; i--) send_bit(which, byt[i]);
    send_bit(which, stop);
  endtask

  task automatic idle(input int n);
    sin4 = 1'b1;
    sin2 = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // data holds {B, A} in its low 16*ob bits; extra frames beyond 2*ob carry 8'h00.
  task automatic send_packet(input int which, input logic [63:0] data, input int ob,
                             input int ndata, input logic [7:0] ctl);
    logic [7:0] byt;
    for (int i = 0; i < ndata; i++) begin
      byt = (i < 2 * ob) ? data[(2 * ob - 1 - i) * 8 +: 8] : 8'h00;
      send_frame(which, 1'b0, byt, 1'b1);
    end
    send_frame(which, 1'b1, ctl, 1'b1);
    idle(3);
  endtask

  function automatic vec_t mk(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                              input int nd, input bit uc, input logic [7:0] ctl,
                              input logic [2:0] ee, input logic [31:0] ea, input logic [31:0] eb,
                              input logic [2:0] eo);
    vec_t v;
    v.b = b; v.a = a; v.op = op; v.ndata = nd; v.use_ctl = uc; v.ctl = ctl;
    v.e_err = ee; v.e_a = ea; v.e_b = eb; v.e_op = eo;
    return v;
  endfunction

  function automatic res_t mkres(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] op, input logic [2:0] err);
    res_t r;
    r.a = a; r.b = b; r.op = op; r.err = err;
    return r;
  endfunction

  // Scoreboard consumer: every accepted result must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && out_valid4 && rdy4) begin
      if (sbq.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_result: got a=%h b=%h op=%b err=%b expected no output",
                 out_a4, out_b4, out_op4, out_err4);
      end else begin
        res_t e;
        e = sbq.pop_front();
        $display("result a=%h b=%h op=%b err=%b", out_a4, out_b4, out_op4, out_err4);
        check("res_a", 64'(out_a4), 64'(e.a));
        check("res_b", 64'(out_b4), 64'(e.b));
        check("res_op", 64'(out_op4), 64'(e.op));
        check("res_err", 64'(out_err4), 64'(e.err));
      end
    end
  end

  // Counts frame-error pulses of the main instance.
  always @(negedge clk) begin
    if (!rst && ferr4) n_ferr++;
  end

  // Captures results of the OP_BYTES=2 instance.
  always @(negedge clk) begin
    if (!rst && out_valid2) begin
      got2++;
      cap_a2 = out_a2; cap_b2 = out_b2; cap_op2 = out_op2; cap_err2 = out_err2;
    end
  end

  initial begin
    logic [7:0]  ctl;
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    int          f0;

    rst = 1'b1; sin4 = 1'b1; sin2 = 1'b1; rdy4 = 1'b1; rdy2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    check("rst_out_valid", 64'(out_valid4), 64'd0);
    check("rst_out_a", 64'(out_a4), 64'd0);
    check("rst_out_b", 64'(out_b4), 64'd0);
    check("rst_out_op", 64'(out_op4), 64'd0);
    check("rst_out_err", 64'(out_err4), 64'd0);
    check("rst_overrun", 64'(ovr4), 64'd0);
    check("rst_frame_err", 64'(ferr4), 64'd0);
    idle(2);

    //             B             A             OP      nd ctl? CTL    err     exp A         exp B         exp OP
    vecs[0]  = mk(32'h00000002, 32'h00000004, 3'b100, 8, 1, 8'h4E, 3'b000, 32'h00000004, 32'h00000002, 3'b100);
    vecs[1]  = mk(32'h00000002, 32'h00000004, 3'b100, 8, 1, 8'h0F, 3'b010, 32'h0,        32'h0,        3'b000);
    vecs[2]  = mk(32'h550F0000, 32'h00000000, 3'b000, 2, 1, 8'h50, 3'b100, 32'h0,        32'h0,        3'b000);
    vecs[3]  = mk(32'h00000002, 32'h00000004, 3'b010, 8, 0, 8'h00, 3'b001, 32'h0,        32'h0,        3'b000);
    vecs[4]  = mk(32'hDEADBEEF, 32'h12345678, 3'b000, 8, 0, 8'h00, 3'b000, 32'h12345678, 32'hDEADBEEF, 3'b000);
    vecs[5]  = mk(32'h0F0F0000, 32'h00FF00FF, 3'b001, 8, 0, 8'h00, 3'b000, 32'h00FF00FF, 32'h0F0F0000, 3'b001);
    vecs[6]  = mk(32'h00000007, 32'h00000009, 3'b111, 8, 0, 8'h00, 3'b001, 32'h0,        32'h0,        3'b000);
    vecs[7]  = mk(32'h00000001, 32'h00000002, 3'b100, 9, 0, 8'h00, 3'b100, 32'h0,        32'h0,        3'b000);
    vecs[8]  = mk(32'h00000001, 32'h00000002, 3'b100, 12, 0, 8'h00, 3'b100, 32'h0,       32'h0,        3'b000);
    vecs[9]  = mk(32'h00000000, 32'h00000000, 3'b100, 0, 0, 8'h00, 3'b100, 32'h0,        32'h0,        3'b000);
    vecs[10] = mk(32'h80000000, 32'h7FFFFFFF, 3'b101, 8, 0, 8'h00, 3'b000, 32'h7FFFFFFF, 32'h80000000, 3'b101);
    vecs[11] = mk(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b011, 8, 0, 8'h00, 3'b001, 32'h0,        32'h0,        3'b000);

    for (int i = 0; i < 12; i++) begin
      ctl = vecs[i].use_ctl ? vecs[i].ctl : {1'b0, vecs[i].op, crc_model({vecs[i].b, vecs[i].a}, 64, vecs[i].op)};
      $display("vec %0d: B=%h A=%h ndata=%0d ctl=%h", i, vecs[i].b, vecs[i].a, vecs[i].ndata, ctl);
      sbq.push_back(mkres(vecs[i].e_a, vecs[i].e_b, vecs[i].e_op, vecs[i].e_err));
      send_packet(4, {vecs[i].b, vecs[i].a}, 4, vecs[i].ndata, ctl);
    end

    // Random legal ADD/SUB packets with a model-computed CRC.
    for (int i = 0; i < 4; i++) begin
      ra = $urandom; rb = $urandom;
      rop = (($urandom % 2) == 0) ? 3'b100 : 3'b101;
      ctl = {1'b0, rop, crc_model({rb, ra}, 64, rop)};
      $display("rand %0d: B=%h A=%h op=%b", i, rb, ra, rop);
      sbq.push_back(mkres(ra, rb, rop, 3'b000));
      send_packet(4, {rb, ra}, 4, 8, ctl);
    end

    // Overrun: hold ready low across two good packets; only the first survives.
    rdy4 = 1'b0;
    sbq.push_back(mkres(32'h11111111, 32'h22222222, 3'b100, 3'b000));
    send_packet(4, {32'h22222222, 32'h11111111}, 4, 8, {1'b0, 3'b100, crc_model({32'h22222222, 32'h11111111}, 64, 3'b100)});
    check("ovr_first_clear", 64'(ovr4), 64'd0);
    send_packet(4, {32'h33333333, 32'h44444444}, 4, 8, {1'b0, 3'b000, crc_model({32'h33333333, 32'h44444444}, 64, 3'b000)});
    $display("overrun: valid=%b a=%h overrun=%b", out_valid4, out_a4, ovr4);
    check("ovr_valid_held", 64'(out_valid4), 64'd1);
    check("ovr_a_held", 64'(out_a4), 64'h11111111);
    check("ovr_sticky_set", 64'(ovr4), 64'd1);
    rdy4 = 1'b1;
    idle(2);
    check("ovr_valid_drop", 64'(out_valid4), 64'd0);
    check("ovr_still_set", 64'(ovr4), 64'd1);

    // Framing error on the third byte, then a clean packet.
    f0 = n_ferr;
    send_frame(4, 1'b0, 8'h00, 1'b1);
    send_frame(4, 1'b0, 8'h00, 1'b1);
    send_frame(4, 1'b0, 8'h00, 1'b0);
    idle(5);
    $display("frame error: pulses=%0d valid=%b", n_ferr - f0, out_valid4);
    check("ferr_pulses", 64'(n_ferr - f0), 64'd1);
    check("ferr_no_valid", 64'(out_valid4), 64'd0);
    sbq.push_back(mkres(32'hFFFFFFFF, 32'h00000000, 3'b101, 3'b000));
    send_packet(4, {32'h00000000, 32'hFFFFFFFF}, 4, 8, {1'b0, 3'b101, crc_model({32'h00000000, 32'hFFFFFFFF}, 64, 3'b101)});

    // Reset in the middle of a packet drops the partial data and clears overrun.
    send_frame(4, 1'b0, 8'hAA, 1'b1);
    send_frame(4, 1'b0, 8'hBB, 1'b1);
    send_frame(4, 1'b0, 8'hCC, 1'b1);
    send_bit(4, 1'b0);
    send_bit(4, 1'b0);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    check("midrst_overrun", 64'(ovr4), 64'd0);
    check("midrst_valid", 64'(out_valid4), 64'd0);
    sbq.push_back(mkres(32'h0000ABCD, 32'h00001234, 3'b000, 3'b000));
    send_packet(4, {32'h00001234, 32'h0000ABCD}, 4, 8, {1'b0, 3'b000, crc_model({32'h00001234, 32'h0000ABCD}, 64, 3'b000)});

    // OP_BYTES=2 instance: 4 DATA frames per packet.
    send_packet(2, {32'h0, 16'h1234, 16'hABCD}, 2, 4, {1'b0, 3'b100, crc_model({32'h0, 16'h1234, 16'hABCD}, 32, 3'b100)});
    $display("op2 good: n=%0d a=%h b=%h op=%b err=%b", got2, cap_a2, cap_b2, cap_op2, cap_err2);
    check("op2_count", 64'(got2), 64'd1);
    check("op2_a", 64'(cap_a2), 64'hABCD);
    check("op2_b", 64'(cap_b2), 64'h1234);
    check("op2_op", 64'(cap_op2), 64'd4);
    check("op2_err", 64'(cap_err2), 64'd0);
    send_packet(2, {32'h0, 16'h1234, 16'hABCD}, 2, 4, {1'b0, 3'b100, ~crc_model({32'h0, 16'h1234, 16'hABCD}, 32, 3'b100)});
    $display("op2 crc: n=%0d a=%h err=%b", got2, cap_a2, cap_err2);
    check("op2_count2", 64'(got2), 64'd2);
    check("op2_crc_err", 64'(cap_err2), 64'b010);
    check("op2_crc_a", 64'(cap_a2), 64'd0);

`ifdef MTM_ALU_RX_TIMEOUT_EN
    // Three frames then silence: the watchdog aborts with ERR_DATA.
    sbq.push_back(mkres(32'h0, 32'h0, 3'b000, 3'b100));
    send_frame(4, 1'b0, 8'h01, 1'b1);
    send_frame(4, 1'b0, 8'h02, 1'b1);
    send_frame(4, 1'b0, 8'h03, 1'b1);
    idle(TMO + 20);
`endif

    idle(20);
    check("sb_drained", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
